inst_rom_arbiter: RTL

- Shares the single combinational instruction ROM between two requesters: the IF-stage fetch port (primary) and a debug/loader read port (secondary).
- Drives the ROM ce/addr pair and registers the returned word, giving each requester a 1-cycle-latency req/gnt/rvalid interface.
- IF has priority. A burst limit guarantees debug progress, and IF receives a stall request while it is denied.
- Sits between pc_reg/if_id and the instruction ROM.

---
 rtl/inst_arb_pkg.sv | 15 +
 rtl/inst_arb_perf.sv | 39 +++
 rtl/inst_rom_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/inst_arb_pkg.sv
// Shared types for the instruction ROM arbiter: ownership state and burst-counter width.
package inst_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_IF  = 2'd1,
    OWN_DBG = 2'd2
  } arb_state_t;

  typedef logic [ADDR_W-1:0] inst_addr_t;

endpackage

// File: rtl/inst_arb_perf.sv
// Grant and stall event counters for the instruction ROM arbiter.
module inst_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_if_gnt,
  input  logic        i_dbg_gnt,
  input  logic        i_if_stall,
  output logic [31:0] o_if_gnt_cnt,
  output logic [31:0] o_dbg_gnt_cnt,
  output logic [31:0] o_if_stall_cnt
);

  logic [31:0] r_if_gnt_cnt;
  logic [31:0] r_dbg_gnt_cnt;
  logic [31:0] r_if_stall_cnt;

  // Clear wins over a same-cycle increment; all counters wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_gnt_cnt   <= '0;
      r_dbg_gnt_cnt  <= '0;
      r_if_stall_cnt <= '0;
    end else if (i_clr) begin
      r_if_gnt_cnt   <= '0;
      r_dbg_gnt_cnt  <= '0;
      r_if_stall_cnt <= '0;
    end else begin
      if (i_if_gnt)   r_if_gnt_cnt   <= r_if_gnt_cnt + 32'd1;
      if (i_dbg_gnt)  r_dbg_gnt_cnt  <= r_dbg_gnt_cnt + 32'd1;
      if (i_if_stall) r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
    end
  end

  assign o_if_gnt_cnt   = r_if_gnt_cnt;
  assign o_dbg_gnt_cnt  = r_dbg_gnt_cnt;
  assign o_if_stall_cnt = r_if_stall_cnt;

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational instruction ROM between IF fetch (priority) and a debug read port.
// Optional INST_ARB_PERF_EN adds grant/stall counters with a synchronous clear.
module inst_rom_arbiter
  import inst_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stallreq,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
`ifdef INST_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_if_gnt_cnt,
  output logic [31:0]       perf_dbg_gnt_cnt,
  output logic [31:0]       perf_if_stall_cnt,
`endif
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  arb_state_t         r_state;
  logic [BURST_W-1:0] r_burst;
  logic               r_if_rvalid;
  logic [DATA_W-1:0]  r_if_rdata;
  logic               r_dbg_rvalid;
  logic [DATA_W-1:0]  r_dbg_rdata;
  logic               r_dbg_err;

  logic w_burst_hit;
  logic w_dbg_win;
  logic w_if_gnt;
  logic w_dbg_gnt;
  logic w_dbg_mis;

  // Debug only steals a slot after IF has held the ROM for MAX_BURST grants in a row.
  assign w_burst_hit = (r_state == OWN_IF) && (r_burst >= BURST_W'(MAX_BURST));
  assign w_dbg_win   = dbg_req && (!if_req || w_burst_hit);

  // Combinational outputs are forced low while reset is held.
  assign w_if_gnt  = rst && if_req && !w_dbg_win;
  assign w_dbg_gnt = rst && w_dbg_win;
  assign w_dbg_mis = w_dbg_gnt && (dbg_addr[1:0] != 2'b00);

  assign if_gnt      = w_if_gnt;
  assign dbg_gnt     = w_dbg_gnt;
  assign if_stallreq = rst && if_req && !w_if_gnt;

  // A misaligned debug access takes its slot but never enables the ROM.
  assign rom_ce   = w_if_gnt || (w_dbg_gnt && !w_dbg_mis);
  assign rom_addr = w_if_gnt  ? if_addr  :
                    w_dbg_gnt ? dbg_addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_burst <= '0;
    end else if (w_if_gnt) begin
      r_state <= OWN_IF;
      if (r_state != OWN_IF)
        r_burst <= BURST_W'(1);
      else if (r_burst != '1)
        r_burst <= r_burst + BURST_W'(1);
    end else if (w_dbg_gnt) begin
      r_state <= OWN_DBG;
      r_burst <= '0;
    end else begin
      r_state <= IDLE;
      r_burst <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
      r_dbg_err    <= 1'b0;
    end else begin
      r_if_rvalid  <= w_if_gnt;
      r_dbg_rvalid <= w_dbg_gnt;
      r_dbg_err    <= w_dbg_mis;
      if (w_if_gnt)
        r_if_rdata <= rom_inst;
      if (w_dbg_gnt)
        r_dbg_rdata <= w_dbg_mis ? '0 : rom_inst;
    end
  end

  assign if_rvalid  = r_if_rvalid;
  assign if_rdata   = r_if_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_err    = r_dbg_err;

`ifdef INST_ARB_PERF_EN
  inst_arb_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (perf_clr),
    .i_if_gnt       (w_if_gnt),
    .i_dbg_gnt      (w_dbg_gnt),
    .i_if_stall     (if_stallreq),
    .o_if_gnt_cnt   (perf_if_gnt_cnt),
    .o_dbg_gnt_cnt  (perf_dbg_gnt_cnt),
    .o_if_stall_cnt (perf_if_stall_cnt)
  );
`endif

endmodule
